// File: rtl/program_loader_pkg.sv
// program_loader_pkg: shared types and constants for the program RAM loader.
// The optional checksum feature of the loader is controlled by the
// PROGRAM_LOADER_CHECKSUM_EN macro (see program_loader.sv).
package program_loader_pkg;

  // Width of one RAM word / one streamed byte.
  localparam int BYTE_W = 8;

  // Program RAM size of the 8-bit CPU.
  localparam int DEFAULT_DEPTH = 16;

  // Loader sequencer states. CSUM is only reachable when the checksum
  // feature is compiled in.
  typedef enum logic [3:0] {
    IDLE       = 4'd0,
    HOLD       = 4'd1,
    RECV       = 4'd2,
    ADDR       = 4'd3,
    WRITE      = 4'd4,
    FILL_ADDR  = 4'd5,
    FILL_WRITE = 4'd6,
    CSUM       = 4'd7,
    FINISH     = 4'd8
  } loader_state_t;

endpackage

// File: rtl/program_loader.sv
// program_loader: boot/reload sequencer for the CPU's program RAM.
// On start it holds the CPU in reset, streams bytes from a valid/ready
// source into RAM from address 0, optionally zero-fills the remainder and
// then releases the CPU.
//
// Handshake: a byte is transferred on a rising clock edge where both
// in_valid and in_ready are high; in_ready is high only while the loader
// waits for a byte (RECV, and CSUM when the checksum feature is present) and
// does not depend combinationally on in_valid.
//
// Optional feature, macro PROGRAM_LOADER_CHECKSUM_EN: the byte carrying
// in_last is a checksum (not written); the mod-256 sum of all data bytes and
// the checksum must be zero, otherwise err is set at the end of the load and
// held until the next start.
module program_loader
  import program_loader_pkg::*;
#(
  parameter int DEPTH       = DEFAULT_DEPTH,
  parameter int ADDR_W      = $clog2(DEPTH),
  parameter int HOLD_CYCLES = 2,
  parameter int ZERO_FILL   = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [BYTE_W-1:0] in_data,
  input  logic              in_last,
  output logic              cpu_hold,
  output logic              mar_load,
  output logic [ADDR_W-1:0] mar_addr,
  output logic              ram_we,
  output logic [BYTE_W-1:0] ram_wdata,
  output logic              busy,
  output logic              done,
  output logic              err
);

  // Highest RAM address; termination is tested against it before any
  // increment so the address counter never wraps.
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
  // Final value of the hold counter before bytes are accepted.
  localparam logic [3:0]        HOLD_LAST = 4'(HOLD_CYCLES - 1);
  localparam bit                FILL_EN   = (ZERO_FILL != 0);

  loader_state_t     state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [3:0]        hold_q, hold_d;
  logic [BYTE_W-1:0] data_q, data_d;
  logic              last_q, last_d;

`ifdef PROGRAM_LOADER_CHECKSUM_EN
  logic [BYTE_W-1:0] csum_q, csum_d;
  logic              err_q, err_d;
`endif

  // State and datapath registers; reset aborts a load immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      addr_q  <= '0;
      hold_q  <= '0;
      data_q  <= '0;
      last_q  <= 1'b0;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
      csum_q  <= '0;
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      hold_q  <= hold_d;
      data_q  <= data_d;
      last_q  <= last_d;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
      csum_q  <= csum_d;
      err_q   <= err_d;
`endif
    end
  end

  // Next-state and datapath update logic.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    hold_d  = hold_q;
    data_d  = data_q;
    last_d  = last_q;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
    csum_d  = csum_q;
    err_d   = err_q;
`endif
    unique case (state_q)
      IDLE: begin
        // start is only looked at here, so it is ignored while busy.
        if (start) begin
          state_d = HOLD;
          addr_d  = '0;
          hold_d  = '0;
          last_d  = 1'b0;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
          csum_d  = '0;
          err_d   = 1'b0;
`endif
        end
      end

      HOLD: begin
        // Give the CPU a few cycles in reset before touching MAR/RAM.
        if (hold_q == HOLD_LAST) begin
          state_d = RECV;
        end else begin
          hold_d = hold_q + 4'd1;
        end
      end

      RECV: begin
        if (in_valid) begin
`ifdef PROGRAM_LOADER_CHECKSUM_EN
          csum_d = csum_q + in_data;
          if (in_last) begin
            // Checksum byte: not stored; fill begins at its would-be slot.
            last_d  = 1'b1;
            data_d  = '0;
            state_d = FILL_EN ? FILL_ADDR : FINISH;
          end else begin
            data_d  = in_data;
            last_d  = 1'b0;
            state_d = ADDR;
          end
`else
          data_d  = in_data;
          last_d  = in_last;
          state_d = ADDR;
`endif
        end
      end

      ADDR: begin
        state_d = WRITE;
      end

      WRITE: begin
        if (addr_q == LAST_ADDR) begin
`ifdef PROGRAM_LOADER_CHECKSUM_EN
          // RAM is full of data; one more byte is taken as the checksum.
          state_d = CSUM;
`else
          state_d = FINISH;
`endif
        end else if (last_q && FILL_EN) begin
          addr_d  = addr_q + 1'b1;
          data_d  = '0;
          state_d = FILL_ADDR;
        end else if (last_q) begin
          state_d = FINISH;
        end else begin
          addr_d  = addr_q + 1'b1;
          state_d = RECV;
        end
      end

      FILL_ADDR: begin
        state_d = FILL_WRITE;
      end

      FILL_WRITE: begin
        if (addr_q == LAST_ADDR) begin
          state_d = FINISH;
        end else begin
          addr_d  = addr_q + 1'b1;
          state_d = FILL_ADDR;
        end
      end

      CSUM: begin
`ifdef PROGRAM_LOADER_CHECKSUM_EN
        // Its in_last is irrelevant: this byte is the checksum by position.
        if (in_valid) begin
          csum_d  = csum_q + in_data;
          state_d = FINISH;
        end
`else
        state_d = IDLE;
`endif
      end

      FINISH: begin
`ifdef PROGRAM_LOADER_CHECKSUM_EN
        err_d = (csum_q != '0);
`endif
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Output strobes decoded from the current state only.
  always_comb begin
    in_ready  = 1'b0;
    cpu_hold  = 1'b0;
    mar_load  = 1'b0;
    mar_addr  = '0;
    ram_we    = 1'b0;
    ram_wdata = '0;
    busy      = (state_q != IDLE);
    done      = 1'b0;
    unique case (state_q)
      IDLE: begin
        cpu_hold = 1'b0;
      end
      HOLD: begin
        cpu_hold = 1'b1;
      end
      RECV, CSUM: begin
        cpu_hold = 1'b1;
        in_ready = 1'b1;
      end
      ADDR, FILL_ADDR: begin
        cpu_hold = 1'b1;
        mar_load = 1'b1;
        mar_addr = addr_q;
      end
      WRITE, FILL_WRITE: begin
        cpu_hold  = 1'b1;
        ram_we    = 1'b1;
        ram_wdata = data_q;
      end
      FINISH: begin
        cpu_hold = 1'b1;
        done     = 1'b1;
      end
      default: begin
        cpu_hold = 1'b0;
      end
    endcase
  end

`ifdef PROGRAM_LOADER_CHECKSUM_EN
  assign err = err_q;
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_program_loader.sv
// tb_program_loader: directed bench for program_loader with a write
// scoreboard. Build with PROGRAM_LOADER_CHECKSUM_EN to cover the checksum
// variant.
module tb_program_loader;

  localparam int DEPTH       = 16;
  localparam int HOLD_CYCLES = 2;
  localparam bit ZERO_FILL   = 1'b1;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
  localparam bit CK = 1'b1;
`else
  localparam bit CK = 1'b0;
`endif

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic       start = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] in_data = 8'h00;
  logic       in_last = 1'b0;
  logic       cpu_hold, mar_load, ram_we, busy, done, err;
  logic [3:0] mar_addr;
  logic [7:0] ram_wdata;

  program_loader #(
    .DEPTH(DEPTH), .HOLD_CYCLES(HOLD_CYCLES), .ZERO_FILL(ZERO_FILL)
  ) dut (
    .clk(clk), .rst(rst), .start(start),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
    .cpu_hold(cpu_hold), .mar_load(mar_load), .mar_addr(mar_addr),
    .ram_we(ram_we), .ram_wdata(ram_wdata),
    .busy(busy), .done(done), .err(err)
  );

  // scoreboard: {addr, data} of every RAM write, in order
  logic [11:0] exp_q[$];
  int n_vec = 0;
  int n_err = 0;
  logic [7:0] stim [0:31];
  logic [3:0] mon_mar = 4'd0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Write monitor: tracks MAR like the real register and checks each write.
  always @(negedge clk) begin
    if (rst) begin
      mon_mar = 4'd0;
    end else begin
      if (mar_load) mon_mar = mar_addr;
      if (ram_we) begin
        n_vec++;
        assert (exp_q.size() != 0) else begin
          n_err++;
          $error("FAIL spurious_write: observed addr %0d data %02h expected no write", mon_mar, ram_wdata);
        end
        if (exp_q.size() != 0) chk("ram_write", {mon_mar, ram_wdata}, exp_q.pop_front());
      end
    end
  end

  // driver tasks (all called at a falling edge)
  task automatic start_load();
    int lat;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("hold_after_start", {cpu_hold, busy}, 2'b11);
    chk("err_cleared_by_start", err, 1'b0);
    lat = 1;
    while (in_ready !== 1'b1 && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    chk("start_to_ready_latency", lat, HOLD_CYCLES + 1);
  endtask

  task automatic send_byte(input logic [7:0] d, input logic l);
    int cnt;
    cnt = 0;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = l;
    while (in_ready !== 1'b1 && cnt < 50) begin
      @(negedge clk);
      cnt++;
    end
    chk("byte_accepted", in_ready, 1'b1);
    @(negedge clk);
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  // After the final accepted byte: keep offering data, nothing may be taken.
  task automatic wait_done(input logic exp_err);
    int cnt;
    cnt = 0;
    in_valid = 1'b1;
    in_data  = 8'hA5;
    while (done !== 1'b1 && cnt < 200) begin
      chk("no_ready_after_last", in_ready, 1'b0);
      chk("hold_during_load", cpu_hold, 1'b1);
      @(negedge clk);
      cnt++;
    end
    chk("done_seen", done, 1'b1);
    chk("hold_at_done", {cpu_hold, busy, in_ready}, 3'b110);
    @(negedge clk);
    #1;
    chk("released_after_done", {done, cpu_hold, busy, in_ready}, 4'b0000);
    chk("err_after_done", err, exp_err);
    chk("all_writes_seen", exp_q.size(), 0);
    in_valid = 1'b0;
    @(negedge clk);
  endtask

  // Runs one load of stim[0..n-1] and models the expected RAM writes.
  task automatic run_load(input int n, input bit with_last, input int gap_max, input bit poke_start);
    int   addr;
    bit   fin, full;
    logic l;
    logic [7:0] sum;
    int   g;
    addr = 0; fin = 1'b0; full = 1'b0; sum = 8'h00;
    start_load();
    for (int i = 0; i < n; i++) begin
      if (!fin) begin
        l   = with_last && (i == n - 1);
        sum = sum + stim[i];
        if (CK && (l || full)) begin
          fin = 1'b1;
          if (!full && ZERO_FILL)
            for (int a = addr; a < DEPTH; a++) exp_q.push_back({4'(a), 8'h00});
        end else begin
          exp_q.push_back({4'(addr), stim[i]});
          if (addr == DEPTH - 1) begin
            if (CK) full = 1'b1; else fin = 1'b1;
          end else if (l) begin
            fin = 1'b1;
            if (ZERO_FILL)
              for (int a = addr + 1; a < DEPTH; a++) exp_q.push_back({4'(a), 8'h00});
          end else begin
            addr++;
          end
        end
        g = (gap_max > 0) ? $urandom_range(0, gap_max) : 0;
        if (poke_start && i == n / 2 && g == 0) g = 1;
        for (int k = 0; k < g; k++) begin
          start = (poke_start && i == n / 2 && k == 0);
          @(negedge clk);
          start = 1'b0;
        end
        send_byte(stim[i], l);
      end
    end
    wait_done(CK ? (sum != 8'h00) : 1'b0);
  endtask

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    // reset state
    repeat (2) @(negedge clk);
    chk("reset_outputs", {in_ready, cpu_hold, mar_load, ram_we, busy, done, err, mar_addr, ram_wdata}, 0);
    rst = 1'b0;
    @(negedge clk);
    chk("idle_after_reset", {busy, cpu_hold, in_ready}, 3'b000);

    // full load 0x10..0x1F, in_last on the 16th
    for (int i = 0; i < 16; i++) stim[i] = 8'(8'h10 + i);
    run_load(16, 1'b1, 0, 1'b0);

    // short load with zero fill
    stim[0] = 8'h51; stim[1] = 8'h2E; stim[2] = 8'hE0; stim[3] = 8'hF0;
    run_load(4, 1'b1, 0, 1'b0);

    // backpressure with random gaps and a stray start mid-load
    for (int i = 0; i < 12; i++) stim[i] = 8'($urandom_range(0, 255));
    run_load(12, 1'b1, 3, 1'b1);

    // overrun: 20 bytes, no in_last
    for (int i = 0; i < 20; i++) stim[i] = 8'($urandom_range(0, 255));
    run_load(20, 1'b0, 1, 1'b0);

    // reset in the middle of the 6th byte
    for (int i = 0; i < 6; i++) stim[i] = 8'($urandom_range(0, 255));
    start_load();
    for (int i = 0; i < 6; i++) begin
      exp_q.push_back({4'(i), stim[i]});
      send_byte(stim[i], 1'b0);
    end
    #1;
    chk("pending_at_abort", exp_q.size(), 1);
    #2;
    rst = 1'b1;
    #1;
    chk("abort_outputs", {in_ready, cpu_hold, mar_load, ram_we, busy, done, err, mar_addr, ram_wdata}, 0);
    exp_q.delete();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("idle_after_abort", {busy, cpu_hold}, 2'b00);
    for (int i = 0; i < 16; i++) stim[i] = 8'($urandom_range(0, 255));
    run_load(16, 1'b1, 1, 1'b0);

`ifdef PROGRAM_LOADER_CHECKSUM_EN
    // good checksum
    stim[0] = 8'h01; stim[1] = 8'h02; stim[2] = 8'hFD;
    run_load(3, 1'b1, 0, 1'b0);
    // bad checksum: err sticky until the next start
    stim[2] = 8'hFC;
    run_load(3, 1'b1, 0, 1'b0);
    repeat (3) @(negedge clk);
    chk("err_sticky", err, 1'b1);
    stim[2] = 8'hFD;
    run_load(3, 1'b1, 0, 1'b0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
